bus_arb: RTL

Two-port arbiter that lets the instruction fetch path and the load/store path share one single-port memory/MMIO bus. It latches one request at a time, drives the shared bus until the memory answers or a watchdog expires, and returns the response to the requester that won. It also produces the core `stall` signal. It sits between the fetch unit and the `mmio` path on one side and the unified memory on the other.

---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/bus_arb_pick.sv | 42 ++++
 rtl/bus_arb.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the bus_arb two-port arbiter.
//   bus_state_t     : arbiter FSM states (IDLE, BUSY, DONE)
//   bus_port_t      : requester identity (PORT_I = fetch, PORT_D = data)
//   FUNCT3_W        : RV32I word access size, used for every fetch
//   TIMEOUT_DEFAULT : default watchdog limit in BUSY cycles
// -----------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } bus_port_t;

    localparam logic [2:0] FUNCT3_W        = 3'b010;
    localparam int         TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner select for bus_arb.
// Configuration macro: BUS_ARB_RR_EN
//   defined   : round-robin, on a tie the port not granted last wins
//   undefined : fixed priority, data over fetch (no last-grant input)
// Ports:
//   last_data_i  in  1  last grant went to the data port (RR build only)
//   fetch_req_i  in  1  fetch request
//   data_req_i   in  1  data request
//   pick_data_o  out 1  1 = data port wins, 0 = fetch port wins
// -----------------------------------------------------------------------------
module arb_pick
    import bus_pkg::*;
(
`ifdef BUS_ARB_RR_EN
    input  logic last_data_i,
`endif
    input  logic fetch_req_i,
    input  logic data_req_i,
    output logic pick_data_o
);

`ifdef BUS_ARB_RR_EN
    always_comb begin
        pick_data_o = data_req_i;
        // On a tie, hand the bus to whichever port did not have it last.
        if (fetch_req_i && data_req_i) begin
            pick_data_o = (bus_port_t'(last_data_i) == PORT_I);
        end
    end
`else
    always_comb begin
        // Data always wins a tie; with a single request the requester wins.
        pick_data_o = data_req_i;
        if (!data_req_i && fetch_req_i) begin
            pick_data_o = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/bus_arb.sv
// -----------------------------------------------------------------------------
// bus_arb
// Shares one single-port memory/MMIO bus between the fetch path and the
// load/store path. One request is latched at a time, the shared bus is driven
// until the memory answers or the watchdog expires, and the response is
// returned to the winning port as a one-cycle ack.
// Configuration macro: BUS_ARB_RR_EN (round-robin tie break; default is fixed
// priority with data over fetch).
// Parameters:
//   TIMEOUT  max BUSY cycles before a forced error completion (1..65535)
//   CNT_W    watchdog counter width
// Ports:
//   clk, rst                    clock, async active-high reset
//   i_req, i_addr               fetch request / word address
//   i_ack, i_rdata              fetch completion pulse / data
//   d_req, d_we, d_funct3       data request / store / RV32I size+sign
//   d_addr, d_wdata             data address / store data
//   d_ack, d_rdata              data completion pulse / load data
//   bus_err                     ack came from a watchdog timeout
//   m_req, m_we, m_funct3       shared bus request / write / size
//   m_addr, m_wdata             shared bus address / write data
//   m_rdata, m_ready            memory read data / completion
//   stall                       core stall, outstanding unacked request
// -----------------------------------------------------------------------------
module bus_arb
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [2:0]  m_funct3,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        stall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_port_t        port_q, port_d;

    logic             m_req_q, m_req_d;
    logic             m_we_q, m_we_d;
    logic [2:0]       m_funct3_q, m_funct3_d;
    logic [31:0]      m_addr_q, m_addr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;

    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      i_rdata_q, i_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic             pick_data;
    logic             any_req;
    logic             finish;
    logic [31:0]      rsp_data;

`ifdef BUS_ARB_RR_EN
    bus_port_t        last_q, last_d;
`endif

    arb_pick u_pick (
`ifdef BUS_ARB_RR_EN
        .last_data_i (last_q == PORT_D),
`endif
        .fetch_req_i (i_req),
        .data_req_i  (d_req),
        .pick_data_o (pick_data)
    );

    assign any_req = i_req | d_req;
    // m_ready takes precedence over a watchdog expiry in the same cycle.
    assign finish   = m_ready || (cnt_q == CNT_LAST);
    assign rsp_data = m_ready ? m_rdata : 32'h0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_funct3_d = m_funct3_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        bus_err_d  = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef BUS_ARB_RR_EN
        last_d     = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    m_req_d = 1'b1;
                    cnt_d   = '0;
                    if (pick_data) begin
                        port_d     = PORT_D;
                        m_we_d     = d_we;
                        m_funct3_d = d_funct3;
                        m_addr_d   = d_addr;
                        m_wdata_d  = d_wdata;
                    end else begin
                        // Fetches are always word reads.
                        port_d     = PORT_I;
                        m_we_d     = 1'b0;
                        m_funct3_d = FUNCT3_W;
                        m_addr_d   = i_addr;
                        m_wdata_d  = 32'h0;
                    end
`ifdef BUS_ARB_RR_EN
                    last_d = pick_data ? PORT_D : PORT_I;
`endif
                end
            end

            BUSY: begin
                if (finish) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    bus_err_d = ~m_ready;
                    if (port_q == PORT_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rsp_data;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rsp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // Ack pulse is visible in this state; always pass through IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            port_q     <= PORT_I;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_funct3_q <= 3'b000;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_funct3_q <= m_funct3_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            bus_err_q  <= bus_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef BUS_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_I;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_funct3 = m_funct3_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;
    assign bus_err  = bus_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
